ifetch_prefetch_buffer: RTL

- Instruction prefetch queue between the pipeline's fetch stage and a variable-latency instruction memory.
- Issues sequential word fetches ahead of the consumer over a req/gnt/rvalid bus and buffers the returned instructions with their PCs in an in-order FIFO.
- Presents the buffered instructions to the IF stage through a valid/ready port.
- A redirect (branch/jump target) flushes the queue, discards in-flight responses and restarts fetching at the new PC.

---
 rtl/ifetch_prefetch_buffer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_buffer
//
// Instruction prefetch queue that sits between the IF stage and a
// variable-latency instruction memory. It runs ahead of the consumer, issuing
// sequential word fetches over a req/gnt/rvalid bus, and keeps the returned
// instructions with their PCs in an in-order FIFO. A redirect flushes the
// queue, discards responses still in flight and restarts at the new PC.
//
// Parameters:
//   DATA_WIDTH - width of addresses, PCs and instruction words
//   DEPTH      - FIFO entries (power of two, >= 2)
//   RESET_PC   - first fetch address after reset
//
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   redirect_valid, redirect_pc  - flush and restart fetch (pc bits [1:0] ignored)
//   out_valid, out_ready         - head-of-queue handshake towards IF
//   out_pc, out_instr            - PC and instruction word of the head entry
//   mem_req, mem_addr, mem_gnt   - fetch request channel
//   mem_rvalid, mem_rdata        - in-order response channel
//
// Optional feature (macro IFETCH_BUS_ERR_EN):
//   Adds mem_err (response error, qualified by mem_rvalid) and out_err (error
//   flag of the head entry). A kept error response halts fetching until the
//   next redirect.
// ---------------------------------------------------------------------------
module ifetch_prefetch_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef IFETCH_BUS_ERR_EN
    ,
    input  logic                  mem_err,
    output logic                  out_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [DATA_WIDTH-1:0] pc_fifo_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_fifo_d [DEPTH];
    logic [DATA_WIDTH-1:0] instr_fifo_q [DEPTH];
    logic [DATA_WIDTH-1:0] instr_fifo_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         discard_q, discard_d;

    logic                  issue;
    logic                  pop;
    logic                  drop;
    logic                  push;
    logic                  fetch_halted;
    logic [CW:0]           in_use;
    logic [DATA_WIDTH-1:0] redirect_aligned;

    // Masking rather than slicing keeps every redirect_pc bit referenced.
    assign redirect_aligned = redirect_pc & ~DATA_WIDTH'(3);

    // Credit rule: FIFO slots plus in-flight requests never exceed DEPTH, so
    // every response that comes back is guaranteed a slot. Only registered
    // state feeds mem_req; reset gating keeps it low while reset is held.
    assign in_use   = {1'b0, count_q} + {1'b0, outstanding_q};
    assign mem_req  = !reset && !fetch_halted && (in_use < DEPTH_C);
    assign mem_addr = fetch_pc_q;

    assign out_valid = (count_q != '0);
    assign out_pc    = pc_fifo_q[rd_ptr_q];
    assign out_instr = instr_fifo_q[rd_ptr_q];

    assign issue = mem_req && mem_gnt;
    assign pop   = out_valid && out_ready;
    // Responses owed to a flushed stream are dropped; a response arriving in
    // the redirect cycle itself is also dropped since the FIFO is being
    // cleared and resp_pc is being reloaded.
    assign drop  = mem_rvalid && (discard_q != '0);
    assign push  = mem_rvalid && !drop && !redirect_valid;

    // Next-state for PCs, counters and FIFO storage. A redirect overrides
    // everything; its discard count is the outstanding count after this
    // cycle's grant/response, so a same-cycle grant is charged to the old
    // stream and back-to-back redirects accumulate naturally.
    always_comb begin
        outstanding_d = outstanding_q + CW'(issue) - CW'(mem_rvalid);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        discard_d     = discard_q;
        pc_fifo_d     = pc_fifo_q;
        instr_fifo_d  = instr_fifo_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outstanding_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            end
            if (drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                pc_fifo_d[wr_ptr_q]    = resp_pc_q;
                instr_fifo_d[wr_ptr_q] = mem_rdata;
                resp_pc_d              = resp_pc_q + DATA_WIDTH'(4);
                wr_ptr_d               = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state: PCs, pointers and counters return to reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // FIFO payload needs no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        pc_fifo_q    <= pc_fifo_d;
        instr_fifo_q <= instr_fifo_d;
    end

`ifdef IFETCH_BUS_ERR_EN
    logic err_fifo_q [DEPTH];
    logic err_fifo_d [DEPTH];
    logic halted_q, halted_d;

    assign fetch_halted = halted_q;
    assign out_err      = out_valid && err_fifo_q[rd_ptr_q];

    // A kept error response stops further fetching until software redirects;
    // the redirect also clears the halt even if an error arrives that cycle.
    always_comb begin
        err_fifo_d = err_fifo_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (push) begin
            err_fifo_d[wr_ptr_q] = mem_err;
            if (mem_err) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        err_fifo_q <= err_fifo_d;
    end
`else
    assign fetch_halted = 1'b0;
`endif

endmodule
